// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds an external full adder one bit pair per
// cycle (LSB first) and collects the sum and final carry into output registers.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [WIDTH:0]   led
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_sh_reg;
    logic             carry_q_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             done_reg;

    always_comb begin
        state_next = state_reg;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_cin     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                fa_a   = a_sh_reg[0];
                fa_b   = b_sh_reg[0];
                fa_cin = carry_q_reg;
                if (cnt_reg == LAST) state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_sh_reg    <= '0;
            carry_q_reg   <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg    <= op_a;
                        b_sh_reg    <= op_b;
                        carry_q_reg <= cin_in;
                        sum_sh_reg  <= '0;
                        cnt_reg     <= '0;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    sum_sh_reg  <= {fa_sum, sum_sh_reg[WIDTH-1:1]};
                    carry_q_reg <= fa_cout;
                    a_sh_reg    <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg    <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    cnt_reg     <= cnt_reg + CW'(1);
                end
                FINISH: begin
                    result_reg    <= sum_sh_reg;
                    carry_out_reg <= carry_q_reg;
                    done_reg      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign led       = {carry_out_reg, result_reg};

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised self-checking bench for serial_add_ctrl with a behavioural full
// adder; expected values come from plain integer addition of the operands.
module tb_serial_add_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_in;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic [WIDTH:0]   led;

    int tests_run = 0;
    int tests_failed = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin_in    (cin_in),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .led       (led)
    );

    // Behavioural full adder on the serial port.
    assign {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        cin_in = c;
    endtask

    // Runs one addition whose start is already driven and is accepted at the
    // next edge (E0). With chain=1 the next start is driven in the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input bit disturb, input bit chain,
                          input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb, input logic nc);
        int expsum;
        int carry_in;
        int mask;
        int waited;
        expsum = int'(a) + int'(b) + int'(c);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (disturb) begin
                start  = 1'b1;
                op_a   = WIDTH'($urandom);
                op_b   = WIDTH'($urandom);
                cin_in = 1'($urandom);
            end
            mask     = (1 << k) - 1;
            carry_in = ((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> k;
            check("busy_shift", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            check("fa_a", 32'(fa_a), 32'(a[k]));
            check("fa_b", 32'(fa_b), 32'(b[k]));
            check("fa_cin", 32'(fa_cin), 32'(carry_in & 1));
            @(posedge clk); #1;
        end
        check("busy_finish", 32'(busy), 32'd1);
        check("fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        check("done_early", 32'(done), 32'd0);
        waited = 0;
        for (int w = 0; w < 4; w++) begin
            @(posedge clk); #1;
            waited++;
            if (done) break;
        end
        check("done_latency", 32'(waited), 32'd1);
        check("result", 32'(result), 32'(expsum & ((1 << WIDTH) - 1)));
        check("carry_out", 32'(carry_out), 32'((expsum >> WIDTH) & 1));
        check("led", 32'(led), 32'(expsum & ((1 << (WIDTH + 1)) - 1)));
        check("busy_done", 32'(busy), 32'd0);
        $display("[TB] op %0d+%0d+%0d -> result=%0d carry=%0d", a, b, c, result, carry_out);
        if (chain) begin
            drive_start(na, nb, nc);
        end else begin
            start = 1'b0;
            @(posedge clk); #1;
            check("done_pulse", 32'(done), 32'd0);
            check("result_hold", 32'(led), 32'(expsum & ((1 << (WIDTH + 1)) - 1)));
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ca, cb, xa, xb;
        logic             cc, xc;
        bit               chn;

        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        cin_in = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        drive_start(4'd0, 4'd0, 1'b0);
        run_op(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_start(4'd5, 4'd3, 1'b0);
        run_op(4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_start(4'd15, 4'd15, 1'b1);
        run_op(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
        drive_start(4'd5, 4'd3, 1'b0);
        run_op(4'd5, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        // Reset in the middle of an addition
        drive_start(4'd9, 4'd6, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_led", 32'(led), 32'd0);
        check("arst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("arst_hold_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(4'd2, 4'd2, 1'b0);
        run_op(4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // Back-to-back
        drive_start(4'd1, 4'd1, 1'b0);
        run_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd8, 1'b1);
        run_op(4'd7, 4'd8, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // Randomised operations, randomly chained and disturbed
        xa = WIDTH'($urandom);
        xb = WIDTH'($urandom);
        xc = 1'($urandom);
        drive_start(xa, xb, xc);
        for (int i = 0; i < 30; i++) begin
            ca = xa; cb = xb; cc = xc;
            xa = WIDTH'($urandom);
            xb = WIDTH'($urandom);
            xc = 1'($urandom);
            chn = (i < 29) && ($urandom_range(0, 1) == 1);
            run_op(ca, cb, cc, 1'($urandom), chn, xa, xb, xc);
            if (!chn && i < 29) drive_start(xa, xb, xc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
